// File: rtl/apb4_to_sram_pkg.sv
// Shared types and address decode for the APB4-to-SRAM bridge.
package apb_sram_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, RESP} state_e;

    // Defaults describe the common 32-bit data path.
    localparam int NUM_STRB   = 4;
    localparam int WORD_SHIFT = $clog2(NUM_STRB);

    typedef struct packed {
        logic        err;
        logic [63:0] index;
    } dec_t;

    // off is already (PADDR - BASE_ADDR) zero-extended, so out-of-range is a plain compare.
    function automatic dec_t addr_decode(input logic [63:0] off, input int depth,
                                         input int shift = WORD_SHIFT);
        dec_t d;
        d.index = off >> shift;
        d.err   = ((off & ((64'd1 << shift) - 64'd1)) != 64'd0) || (d.index >= 64'(depth));
        return d;
    endfunction

endpackage

// File: rtl/apb4_to_sram_if.sv
// APB4 requester/completer bus and single-port SRAM bus.
interface apb4_if #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic [2:0]              PPROT;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
                    output PRDATA, PREADY, PSLVERR);
endinterface

interface sram_if #(parameter int IDX_W = 10, parameter int DATA_WIDTH = 32);
    logic [IDX_W-1:0]        SRAM_ADDR;
    logic                    SRAM_CE;
    logic [DATA_WIDTH/8-1:0] SRAM_WE;
    logic                    SRAM_OE;
    logic [DATA_WIDTH-1:0]   SRAM_WDATA;
    logic [DATA_WIDTH-1:0]   SRAM_RDATA;

    modport master (output SRAM_ADDR, SRAM_CE, SRAM_WE, SRAM_OE, SRAM_WDATA,
                    input  SRAM_RDATA);
    modport slave  (input  SRAM_ADDR, SRAM_CE, SRAM_WE, SRAM_OE, SRAM_WDATA,
                    output SRAM_RDATA);
endinterface

// File: rtl/apb4_to_sram_rd_latency_ctr.sv
// Read-latency down-counter: load on read issue, done in the last wait cycle.
module sram_rd_latency_ctr #(
    parameter int RD_LATENCY = 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic load,
    input  logic en,
    output logic done
);
    localparam int CW = $clog2(RD_LATENCY + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                cnt <= '0;
        else if (load)             cnt <= CW'(RD_LATENCY);
        else if (en && cnt != '0)  cnt <= cnt - CW'(1);
    end

    // Fires on the edge where the count hits zero, i.e. when RDATA is capturable.
    assign done = en && (cnt == CW'(1));
endmodule

// File: rtl/apb4_to_sram.sv
// APB4 completer bridging to a single-port synchronous SRAM with byte strobes,
// read wait states, base-address decode and PSLVERR on bad addresses.
module apb4_to_sram
    import apb_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8 * NUM_STRB,
    parameter int MEM_DEPTH  = 1024,
    parameter int RD_LATENCY = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input logic   CLK,
    input logic   RST_N,
    apb4_if.slave apb,
    sram_if.master sram
);
    localparam int NSTRB = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(NSTRB);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_e                state, state_n;
    logic [ADDR_WIDTH-1:0] off;
    dec_t                  dec;
    logic                  setup, load, done;
    logic                  unused_bits;

    logic [DATA_WIDTH-1:0] prdata_q, prdata_n, wdata_q, wdata_n;
    logic [IDX_W-1:0]      addr_q, addr_n;
    logic [NSTRB-1:0]      we_q, we_n;
    logic                  pready_q, pready_n, pslverr_q, pslverr_n;
    logic                  ce_q, ce_n, oe_q, oe_n;

    assign setup       = apb.PSEL && !apb.PENABLE;
    assign off         = apb.PADDR - BASE_ADDR;
    assign dec         = addr_decode(64'(off), MEM_DEPTH, SHIFT);
    assign load        = (state == IDLE) && setup && !dec.err && !apb.PWRITE;
    assign unused_bits = ^{apb.PPROT, dec.index[63:IDX_W]};

    sram_rd_latency_ctr #(.RD_LATENCY(RD_LATENCY)) u_rd_ctr (
        .CLK   (CLK),
        .RST_N (RST_N),
        .load  (load),
        .en    (state == READ_WAIT),
        .done  (done)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= '0;
            ce_q      <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state     <= state_n;
            prdata_q  <= prdata_n;
            pready_q  <= pready_n;
            pslverr_q <= pslverr_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            we_q      <= we_n;
            ce_q      <= ce_n;
            oe_q      <= oe_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (setup) state_n = dec.err ? RESP : (apb.PWRITE ? WRITE : READ_WAIT);
            WRITE:     state_n = IDLE;
            READ_WAIT: if (!apb.PSEL) state_n = IDLE;
                       else if (done) state_n = RESP;
            RESP:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Strobes and PREADY default low so every pulse lasts exactly one cycle.
    always_comb begin
        prdata_n  = prdata_q;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        pready_n  = 1'b0;
        pslverr_n = 1'b0;
        we_n      = '0;
        ce_n      = 1'b0;
        oe_n      = 1'b0;
        case (state)
            IDLE: if (setup) begin
                if (dec.err) begin
                    pready_n  = 1'b1;
                    pslverr_n = 1'b1;
                    prdata_n  = '0;
                end else begin
                    addr_n = dec.index[IDX_W-1:0];
                    ce_n   = 1'b1;
                    if (apb.PWRITE) begin
                        wdata_n  = apb.PWDATA;
                        we_n     = apb.PSTRB;
                        pready_n = 1'b1;
                    end else begin
                        oe_n = 1'b1;
                    end
                end
            end
            READ_WAIT: if (apb.PSEL && done) begin
                prdata_n = sram.SRAM_RDATA;
                pready_n = 1'b1;
            end
            default: ;
        endcase
    end

    assign apb.PRDATA      = prdata_q;
    assign apb.PREADY      = pready_q;
    assign apb.PSLVERR     = pslverr_q;
    assign sram.SRAM_ADDR  = addr_q;
    assign sram.SRAM_WDATA = wdata_q;
    assign sram.SRAM_WE    = we_q;
    assign sram.SRAM_CE    = ce_q;
    assign sram.SRAM_OE    = oe_q;
endmodule

// File: tb/tb_apb4_to_sram.sv
// Directed bench for apb4_to_sram with an inline single-port SRAM model.
module tb_apb4_to_sram;
    import apb_sram_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0, total = 0;
    int   ce_cnt = 0, ce_viol = 0, pready_viol = 0;
    logic ce_prev = 1'b0, pready_prev = 1'b0;

    apb4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();
    sram_if #(.IDX_W(4), .DATA_WIDTH(32))       sram ();

    apb4_to_sram #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(12),
        .RD_LATENCY(2), .BASE_ADDR(32'h1000)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .apb(apb), .sram(sram)
    );

    always #5 clk = ~clk;

    // SRAM model: CE/OE sampled on an edge, data registered there and captured by
    // the bridge on the following edge (two edges after issue = RD_LATENCY 2).
    logic [31:0] mem [12];
    logic [31:0] rd_q;
    assign sram.SRAM_RDATA = rd_q;

    always @(posedge clk) begin
        if (sram.SRAM_CE && int'(sram.SRAM_ADDR) < 12) begin
            if (sram.SRAM_OE) rd_q <= mem[sram.SRAM_ADDR];
            for (int b = 0; b < 4; b++)
                if (sram.SRAM_WE[b]) mem[sram.SRAM_ADDR][8*b +: 8] <= sram.SRAM_WDATA[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (sram.SRAM_CE) ce_cnt++;
        if (sram.SRAM_CE && ce_prev) ce_viol++;
        if (apb.PREADY && pready_prev) pready_viol++;
        ce_prev     = sram.SRAM_CE;
        pready_prev = apb.PREADY;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE0000 + 32'(i) * 32'h111;
    endfunction

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output logic err, output int waits);
        @(posedge clk); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr;
        apb.PADDR = addr; apb.PWDATA = wdata; apb.PSTRB = strb;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        waits = 0;
        while (apb.PREADY !== 1'b1 && waits < 16) begin
            @(posedge clk); #1;
            waits++;
        end
        rdata = apb.PRDATA;
        err   = apb.PSLVERR;
    endtask

    task automatic apb_idle();
        @(posedge clk); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          w, c0, seen;

    initial begin
        rst_n = 1'b0;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0; apb.PSTRB = '0; apb.PPROT = 3'b010;
        repeat (2) @(posedge clk); #1;
        check("rst_flags", 32'({apb.PREADY, apb.PSLVERR, sram.SRAM_CE, sram.SRAM_OE, sram.SRAM_WE}), 32'h0);
        check("rst_prdata", apb.PRDATA, 32'h0);
        check("rst_addr", 32'(sram.SRAM_ADDR), 32'h0);
        check("rst_wdata", sram.SRAM_WDATA, 32'h0);
        rst_n = 1'b1;

        // Full write then read
        apb_xfer(1'b1, 32'h1008, 32'hDEADBEEF, 4'hF, rd, er, w);
        check("wr_waits", 32'(w), 32'd0);
        check("wr_err", 32'(er), 32'd0);
        apb_xfer(1'b0, 32'h1008, 32'h0, 4'h0, rd, er, w);
        check("rd_data", rd, 32'hDEADBEEF);
        check("rd_waits", 32'(w), 32'd2);
        check("rd_err", 32'(er), 32'd0);

        // Byte strobes
        apb_xfer(1'b1, 32'h1000, 32'h11223344, 4'hF, rd, er, w);
        apb_xfer(1'b1, 32'h1000, 32'hAABBCCDD, 4'h5, rd, er, w);
        apb_xfer(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, w);
        check("strb5_data", rd, 32'h11BB33DD);
        c0 = ce_cnt;
        apb_xfer(1'b1, 32'h1000, 32'hFFFFFFFF, 4'h0, rd, er, w);
        check("strb0_err", 32'(er), 32'd0);
        check("strb0_waits", 32'(w), 32'd0);
        apb_idle();
        check("strb0_ce", 32'(ce_cnt - c0), 32'd1);
        apb_xfer(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, w);
        check("strb0_data", rd, 32'h11BB33DD);

        // Error responses: no CE pulse, PRDATA cleared
        c0 = ce_cnt;
        apb_xfer(1'b0, 32'h1002, 32'h0, 4'h0, rd, er, w);
        check("mis_err", 32'(er), 32'd1);
        check("mis_waits", 32'(w), 32'd0);
        check("mis_prdata", rd, 32'h0);
        apb_xfer(1'b0, 32'h1008, 32'h0, 4'h0, rd, er, w);
        check("rd_again", rd, 32'hDEADBEEF);
        apb_xfer(1'b0, 32'h1030, 32'h0, 4'h0, rd, er, w);
        check("oor_err", 32'(er), 32'd1);
        check("oor_prdata", rd, 32'h0);
        apb_xfer(1'b1, 32'h0FFC, 32'h12345678, 4'hF, rd, er, w);
        check("below_err", 32'(er), 32'd1);
        check("below_waits", 32'(w), 32'd0);
        apb_idle();
        check("err_ce", 32'(ce_cnt - c0), 32'd1);

        // Last valid word
        apb_xfer(1'b1, 32'h102C, 32'h0BADF00D, 4'hF, rd, er, w);
        check("last_wr_err", 32'(er), 32'd0);
        apb_xfer(1'b0, 32'h102C, 32'h0, 4'h0, rd, er, w);
        check("last_rd_data", rd, 32'h0BADF00D);
        check("last_rd_err", 32'(er), 32'd0);

        // Back-to-back write/read across every index
        for (int i = 0; i < 12; i++) begin
            apb_xfer(1'b1, 32'h1000 + 32'(4 * i), pat(i), 4'hF, rd, er, w);
            apb_xfer(1'b0, 32'h1000 + 32'(4 * i), 32'h0, 4'h0, rd, er, w);
            check($sformatf("b2b_rd%0d", i), rd, pat(i));
        end
        apb_idle();
        check("ce_one_cycle", 32'(ce_viol), 32'd0);
        check("pready_one_cycle", 32'(pready_viol), 32'd0);

        // Reset in the second READ_WAIT cycle
        @(posedge clk); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 32'h100C;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", 32'({apb.PREADY, apb.PSLVERR, sram.SRAM_CE, sram.SRAM_OE, sram.SRAM_WE}), 32'h0);
        check("mid_rst_prdata", apb.PRDATA, 32'h0);
        check("mid_rst_addr", 32'(sram.SRAM_ADDR), 32'h0);
        check("mid_rst_wdata", sram.SRAM_WDATA, 32'h0);
        c0 = ce_cnt;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_no_ce", 32'(ce_cnt - c0), 32'd0);
        apb_xfer(1'b0, 32'h100C, 32'h0, 4'h0, rd, er, w);
        check("post_rst_data", rd, pat(3));
        check("post_rst_waits", 32'(w), 32'd2);

        // PSEL dropped during READ_WAIT
        @(posedge clk); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 32'h1008;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        @(posedge clk); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        @(posedge clk); #1;
        check("drop_pready", 32'(apb.PREADY), 32'd0);
        check("drop_state", 32'(dut.state), 32'(IDLE));
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (apb.PREADY) seen++;
        end
        check("drop_no_pready", 32'(seen), 32'd0);
        apb_xfer(1'b0, 32'h1010, 32'h0, 4'h0, rd, er, w);
        check("drop_next_data", rd, pat(4));
        check("drop_next_waits", 32'(w), 32'd2);
        apb_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
